// File: rtl/lc_fabric_pkg.sv
// ============================================================================
// Module      : lc_fabric_pkg
// Description : Shared types and constants for the line-card fabric blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lc_fabric_pkg;

  localparam int          LC_NUM_PORTS = 24;
  localparam int          LC_PORT_BITS = $clog2(LC_NUM_PORTS);
  // 2400 beats x 32 bit covers a 9600-byte jumbo frame
  localparam logic [15:0] LC_MAX_BEATS = 16'd2400;

  typedef logic [LC_PORT_BITS-1:0] port_idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FWD     = 2'd1,
    DISCARD = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_priority_picker.sv
// ============================================================================
// Module      : rr_priority_picker
// Description : Combinational round-robin picker; first request at or after
//               the pointer, wrapping modulo NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_picker
  import lc_fabric_pkg::*;
#(
  parameter int NUM_REQ  = LC_NUM_PORTS,
  parameter int IDX_BITS = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  i_req,
  input  logic [IDX_BITS-1:0] i_ptr,
  output logic                o_valid,
  output logic [IDX_BITS-1:0] o_idx
);

  localparam logic [IDX_BITS:0] c_num_req = (IDX_BITS+1)'(NUM_REQ);

  logic [IDX_BITS:0] w_pos;

  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_pos   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_pos = {1'b0, i_ptr} + (IDX_BITS+1)'(i);
      if (w_pos >= c_num_req) begin
        w_pos = w_pos - c_num_req;
      end
      if (!o_valid && i_req[w_pos[IDX_BITS-1:0]]) begin
        o_valid = 1'b1;
        o_idx   = w_pos[IDX_BITS-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/lc_ingress_arbiter.sv
// ============================================================================
// Module      : lc_ingress_arbiter
// Description : Frame-atomic round-robin ingress arbiter with source-port
//               tagging and max-length truncation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lc_ingress_arbiter
  import lc_fabric_pkg::*;
#(
  parameter int          NUM_PORTS  = LC_NUM_PORTS,
  parameter int          DATA_WIDTH = 32,
  parameter int          PORT_BITS  = $clog2(NUM_PORTS),
  parameter logic [15:0] MAX_BEATS  = LC_MAX_BEATS
) (
  input  logic                            clk_fabric,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            s_tvalid,
  output logic [NUM_PORTS-1:0]            s_tready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_PORTS-1:0]            s_tlast,
  input  logic [NUM_PORTS-1:0]            s_tuser,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic [DATA_WIDTH-1:0]           m_tdata,
  output logic                            m_tlast,
  output logic                            m_tuser,
  output logic [PORT_BITS-1:0]            m_tid,
  output logic                            busy,
  output logic                            trunc_pulse,
  output logic [PORT_BITS-1:0]            trunc_port
);

  localparam logic [PORT_BITS-1:0] c_last_port = PORT_BITS'(NUM_PORTS - 1);

  arb_state_t            r_state, w_state_nxt;
  logic [PORT_BITS-1:0]  r_grant, r_rr_ptr, w_rr_nxt, w_pick_idx;
  logic                  w_pick_valid;
  logic [15:0]           r_beat_cnt;
  logic [DATA_WIDTH-1:0] w_port_data [NUM_PORTS];
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_sel_valid, w_sel_last, w_sel_user;
  logic                  w_out_free, w_fwd_acc, w_disc_acc, w_trunc;
  logic                  r_m_tvalid, r_m_tlast, r_m_tuser, r_trunc_pulse;
  logic [DATA_WIDTH-1:0] r_m_tdata;
  logic [PORT_BITS-1:0]  r_m_tid, r_trunc_port;

  generate
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
      assign w_port_data[g] = s_tdata[g*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  rr_priority_picker #(
    .NUM_REQ  (NUM_PORTS),
    .IDX_BITS (PORT_BITS)
  ) u_picker (
    .i_req   (s_tvalid),
    .i_ptr   (r_rr_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  assign w_sel_valid = s_tvalid[r_grant];
  assign w_sel_last  = s_tlast[r_grant];
  assign w_sel_user  = s_tuser[r_grant];
  assign w_sel_data  = w_port_data[r_grant];
  assign w_out_free  = !r_m_tvalid || m_tready;
  assign w_fwd_acc   = (r_state == FWD) && w_sel_valid && w_out_free;
  assign w_disc_acc  = (r_state == DISCARD) && w_sel_valid;
  // A frame of exactly MAX_BEATS with tlast on its last beat is not truncated
  assign w_trunc     = w_fwd_acc && !w_sel_last && (r_beat_cnt == MAX_BEATS - 16'd1);
  assign w_rr_nxt    = (r_grant == c_last_port) ? '0 : r_grant + 1'b1;

  always_ff @(posedge clk_fabric or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    s_tready    = '0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) w_state_nxt = FWD;
      end
      FWD: begin
        s_tready[r_grant] = w_out_free;
        if (w_fwd_acc && w_sel_last) w_state_nxt = IDLE;
        else if (w_trunc)            w_state_nxt = DISCARD;
      end
      DISCARD: begin
        s_tready[r_grant] = 1'b1;
        if (w_disc_acc && w_sel_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_fabric or posedge rst) begin
    if (rst) begin
      r_grant       <= '0;
      r_rr_ptr      <= '0;
      r_beat_cnt    <= '0;
      r_m_tvalid    <= 1'b0;
      r_m_tdata     <= '0;
      r_m_tlast     <= 1'b0;
      r_m_tuser     <= 1'b0;
      r_m_tid       <= '0;
      r_trunc_pulse <= 1'b0;
      r_trunc_port  <= '0;
    end else begin
      if (r_state == IDLE && w_pick_valid) begin
        r_grant    <= w_pick_idx;
        r_beat_cnt <= '0;
      end else if (w_fwd_acc) begin
        r_beat_cnt <= r_beat_cnt + 16'd1;
      end
      if ((w_fwd_acc || w_disc_acc) && w_sel_last) begin
        r_rr_ptr <= w_rr_nxt;
      end
      // Single output stage: load on accept, otherwise hold until drained
      if (w_fwd_acc) begin
        r_m_tvalid <= 1'b1;
        r_m_tdata  <= w_sel_data;
        r_m_tlast  <= w_sel_last | w_trunc;
        r_m_tuser  <= w_sel_user | w_trunc;
        r_m_tid    <= r_grant;
      end else if (m_tready) begin
        r_m_tvalid <= 1'b0;
      end
      r_trunc_pulse <= w_trunc;
      if (w_trunc) begin
        r_trunc_port <= r_grant;
      end
    end
  end

  assign m_tvalid    = r_m_tvalid;
  assign m_tdata     = r_m_tdata;
  assign m_tlast     = r_m_tlast;
  assign m_tuser     = r_m_tuser;
  assign m_tid       = r_m_tid;
  assign busy        = (r_state != IDLE);
  assign trunc_pulse = r_trunc_pulse;
  assign trunc_port  = r_trunc_port;

endmodule

`default_nettype wire

// File: tb/tb_lc_ingress_arbiter.sv
// ============================================================================
// Module      : tb_lc_ingress_arbiter
// Description : Scoreboard bench for lc_ingress_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lc_ingress_arbiter;
  import lc_fabric_pkg::*;

  localparam int NP   = 24;
  localparam int DW   = 32;
  localparam int PB   = 5;
  localparam int MAXB = 2400;

  logic               clk_fabric = 1'b0;
  logic               rst;
  logic [NP-1:0]      s_tvalid, s_tready, s_tlast, s_tuser;
  logic [NP*DW-1:0]   s_tdata;
  logic               m_tvalid, m_tready, m_tlast, m_tuser, busy, trunc_pulse;
  logic [DW-1:0]      m_tdata;
  logic [PB-1:0]      m_tid, trunc_port;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        user;
    port_idx_t   tid;
  } beat_t;

  beat_t exp_q[$];
  int    n_total = 0;
  int    n_pass  = 0;
  int    trunc_cnt = 0;
  bit    sb_en = 1'b1;
  bit    bp_en = 1'b0;

  always #5 clk_fabric = ~clk_fabric;

  lc_ingress_arbiter dut (
    .clk_fabric  (clk_fabric),
    .rst         (rst),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .s_tdata     (s_tdata),
    .s_tlast     (s_tlast),
    .s_tuser     (s_tuser),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tdata     (m_tdata),
    .m_tlast     (m_tlast),
    .m_tuser     (m_tuser),
    .m_tid       (m_tid),
    .busy        (busy),
    .trunc_pulse (trunc_pulse),
    .trunc_port  (trunc_port)
  );

  // Output monitor: pops the scoreboard on every handshake and checks hold stability
  task automatic monitor();
    beat_t e, prev;
    bit    prev_stall;
    prev_stall = 1'b0;
    prev       = '0;
    forever begin
      @(negedge clk_fabric);
      if (trunc_pulse) trunc_cnt++;
      if (sb_en && !rst) begin
        if (prev_stall) begin
          n_total++;
          if ({m_tvalid, m_tdata, m_tlast, m_tuser, m_tid} !== {1'b1, prev}) begin
            $display("FAIL hold_stable: got %h required %h", {m_tvalid, m_tdata, m_tlast, m_tuser, m_tid}, {1'b1, prev});
          end else n_pass++;
        end
        if (m_tvalid && m_tready) begin
          n_total++;
          if (exp_q.size() == 0) begin
            $display("FAIL unexpected_beat: got data %h tid %0d, required no beat", m_tdata, m_tid);
          end else begin
            e = exp_q.pop_front();
            if ({m_tdata, m_tlast, m_tuser, m_tid} !== e) begin
              $display("FAIL beat: got data %h last %b user %b tid %0d, required data %h last %b user %b tid %0d",
                       m_tdata, m_tlast, m_tuser, m_tid, e.data, e.last, e.user, e.tid);
            end else n_pass++;
          end
        end
        prev_stall = m_tvalid && !m_tready;
        prev       = {m_tdata, m_tlast, m_tuser, m_tid};
      end else begin
        prev_stall = 1'b0;
      end
    end
  endtask

  task automatic bp_driver();
    forever begin
      @(posedge clk_fabric);
      #1;
      m_tready = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  endtask

  task automatic push_frame(input int p, input int n, input logic [31:0] base,
                            input logic [31:0] step, input logic user);
    beat_t e;
    for (int b = 0; b < n && b < MAXB; b++) begin
      e.data = base + step * b;
      e.last = (b == n - 1) || (b == MAXB - 1);
      e.user = user || ((b == MAXB - 1) && (n > MAXB));
      e.tid  = port_idx_t'(p);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_frame(input int p, input int n, input logic [31:0] base,
                            input logic [31:0] step, input logic user);
    int waited;
    for (int b = 0; b < n; b++) begin
      s_tdata[p*DW +: DW] = base + step * b;
      s_tlast[p]  = (b == n - 1);
      s_tuser[p]  = user;
      s_tvalid[p] = 1'b1;
      waited = 0;
      @(negedge clk_fabric);
      while (!s_tready[p]) begin
        waited++;
        if (waited > 3000) begin
          n_total++;
          $display("FAIL send_timeout port %0d beat %0d: s_tready 0, required 1", p, b);
          s_tvalid[p] = 1'b0;
          s_tlast[p]  = 1'b0;
          return;
        end
        @(negedge clk_fabric);
      end
      @(posedge clk_fabric);
      #1;
    end
    s_tvalid[p] = 1'b0;
    s_tlast[p]  = 1'b0;
    s_tuser[p]  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || busy) && c < 6000) begin
      @(posedge clk_fabric);
      c++;
    end
    repeat (2) @(posedge clk_fabric);
    @(negedge clk_fabric);
    n_total++;
    if (exp_q.size() != 0 || busy !== 1'b0 || m_tvalid !== 1'b0) begin
      $display("FAIL drain_%s: pending %0d busy %b m_tvalid %b, required 0 0 0", name, exp_q.size(), busy, m_tvalid);
    end else n_pass++;
    @(posedge clk_fabric);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk_fabric);
    @(negedge clk_fabric);
    n_total++;
    if ({s_tready, m_tvalid, busy, trunc_pulse} !== '0) begin
      $display("FAIL reset_ctrl: got %h required 0", {s_tready, m_tvalid, busy, trunc_pulse});
    end else n_pass++;
    n_total++;
    if ({m_tdata, m_tlast, m_tuser, m_tid, trunc_port} !== '0) begin
      $display("FAIL reset_data: got %h required 0", {m_tdata, m_tlast, m_tuser, m_tid, trunc_port});
    end else n_pass++;
    @(posedge clk_fabric);
    #1;
    rst = 1'b0;
    @(posedge clk_fabric);
    #1;
  endtask

  task automatic test_single();
    push_frame(5, 4, 32'h11, 32'h11, 1'b0);
    fork
      send_frame(5, 4, 32'h11, 32'h11, 1'b0);
      begin
        @(negedge clk_fabric);
        n_total++;
        if ({busy, m_tvalid} !== 2'b00) $display("FAIL lat_c0: got busy/valid %b required 00", {busy, m_tvalid});
        else n_pass++;
        @(negedge clk_fabric);
        n_total++;
        if ({busy, m_tvalid} !== 2'b10) $display("FAIL lat_c1: got busy/valid %b required 10", {busy, m_tvalid});
        else n_pass++;
        @(negedge clk_fabric);
        n_total++;
        if ({m_tvalid, m_tdata, m_tid} !== {1'b1, 32'h11, 5'd5}) begin
          $display("FAIL lat_c2: got valid %b data %h tid %0d required 1 00000011 5", m_tvalid, m_tdata, m_tid);
        end else n_pass++;
      end
    join
    wait_drain("single");
    // Pointer is now 6: with 4 and 6 both requesting, 6 must win
    push_frame(6, 1, 32'h600, 32'h1, 1'b0);
    push_frame(4, 1, 32'h400, 32'h1, 1'b0);
    fork
      send_frame(4, 1, 32'h400, 32'h1, 1'b0);
      send_frame(6, 1, 32'h600, 32'h1, 1'b0);
    join
    wait_drain("rr_after_5");
  endtask

  task automatic test_wrap();
    push_frame(23, 2, 32'h2300, 32'h1, 1'b0);
    send_frame(23, 2, 32'h2300, 32'h1, 1'b0);
    wait_drain("wrap");
  endtask

  task automatic test_multi();
    push_frame(0, 1, 32'hA000, 32'h1, 1'b0);
    push_frame(3, 1, 32'hA300, 32'h1, 1'b1);
    push_frame(23, 1, 32'hA230, 32'h1, 1'b0);
    push_frame(0, 1, 32'hB000, 32'h1, 1'b0);
    fork
      begin
        send_frame(0, 1, 32'hA000, 32'h1, 1'b0);
        send_frame(0, 1, 32'hB000, 32'h1, 1'b0);
      end
      send_frame(3, 1, 32'hA300, 32'h1, 1'b1);
      send_frame(23, 1, 32'hA230, 32'h1, 1'b0);
    join
    wait_drain("multi");
  endtask

  task automatic test_trunc();
    trunc_cnt = 0;
    push_frame(2, MAXB + 5, 32'h0200_0000, 32'h1, 1'b0);
    send_frame(2, MAXB + 5, 32'h0200_0000, 32'h1, 1'b0);
    wait_drain("trunc");
    n_total++;
    if (trunc_cnt !== 1) $display("FAIL trunc_pulse_cycles: got %0d required 1", trunc_cnt);
    else n_pass++;
    n_total++;
    if (trunc_port !== 5'd2) $display("FAIL trunc_port: got %0d required 2", trunc_port);
    else n_pass++;
    trunc_cnt = 0;
    push_frame(8, MAXB, 32'h0800_0000, 32'h1, 1'b0);
    send_frame(8, MAXB, 32'h0800_0000, 32'h1, 1'b0);
    wait_drain("exact_max");
    n_total++;
    if (trunc_cnt !== 0 || trunc_port !== 5'd2) begin
      $display("FAIL exact_max_no_trunc: got pulses %0d port %0d required 0 2", trunc_cnt, trunc_port);
    end else n_pass++;
  endtask

  task automatic test_backpressure();
    for (int run = 0; run < 2; run++) begin
      bp_en = (run == 1);
      push_frame(9, 6, 32'h9000, 32'h3, 1'b0);
      push_frame(12, 3, 32'hC000, 32'h5, 1'b1);
      fork
        send_frame(9, 6, 32'h9000, 32'h3, 1'b0);
        send_frame(12, 3, 32'hC000, 32'h5, 1'b1);
      join
      wait_drain(run == 1 ? "bp_on" : "bp_off");
    end
    bp_en = 1'b0;
    @(posedge clk_fabric);
    #1;
  endtask

  task automatic test_reset_mid();
    push_frame(10, 1, 32'h1000, 32'h1, 1'b0);
    send_frame(10, 1, 32'h1000, 32'h1, 1'b0);
    wait_drain("pre_reset");
    sb_en = 1'b0;
    s_tdata[4*DW +: DW] = 32'h4444_0000;
    s_tlast[4]  = 1'b0;
    s_tvalid[4] = 1'b1;
    repeat (3) @(posedge clk_fabric);
    #1;
    rst = 1'b1;
    @(negedge clk_fabric);
    n_total++;
    if ({s_tready, m_tvalid, busy} !== '0) begin
      $display("FAIL mid_reset: got tready %h valid %b busy %b required 0 0 0", s_tready, m_tvalid, busy);
    end else n_pass++;
    @(posedge clk_fabric);
    #1;
    rst = 1'b0;
    s_tvalid[4] = 1'b0;
    exp_q.delete();
    sb_en = 1'b1;
    // Pointer must restart at 0, so 7 beats 20
    push_frame(7, 2, 32'h7000, 32'h1, 1'b0);
    push_frame(20, 1, 32'h2000, 32'h1, 1'b0);
    fork
      send_frame(20, 1, 32'h2000, 32'h1, 1'b0);
      send_frame(7, 2, 32'h7000, 32'h1, 1'b0);
    join
    wait_drain("post_reset");
  endtask

  initial begin
    rst      = 1'b1;
    m_tready = 1'b1;
    s_tvalid = '0;
    s_tdata  = '0;
    s_tlast  = '0;
    s_tuser  = '0;
    fork
      monitor();
      bp_driver();
    join_none
    test_reset();
    test_single();
    test_wrap();
    test_multi();
    test_trunc();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lc_ingress_arbiter.md
Name: lc_ingress_arbiter

Overview:
Frame-atomic round-robin arbiter that shares the single switch-fabric ingress datapath among the line card RX streams (24 QSGMII-derived ports, already moved into the fabric clock domain). It grants one port at a time for a whole frame and tags each output beat with the source port index for the fabric's VLAN/forwarding lookup. It also enforces a maximum frame length: a runaway or jabbering port is truncated and flagged instead of holding the fabric forever.

Parameters:
NUM_PORTS, 24, number of ingress requesters
DATA_WIDTH, 32, AXI-Stream tdata width per port
PORT_BITS, $clog2(NUM_PORTS), width of the source-port tag
MAX_BEATS, 16'd2400, maximum beats per frame before forced truncation (2400 x 32 bit covers a 9600-byte jumbo frame)

Ports:
clk_fabric  in  1  fabric clock; all logic is in this domain
rst  in  1  asynchronous reset, active high
s_tvalid  in  NUM_PORTS  per-port valid
s_tready  out  NUM_PORTS  per-port ready
s_tdata  in  NUM_PORTS*DATA_WIDTH  per-port data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
s_tlast  in  NUM_PORTS  per-port end of frame
s_tuser  in  NUM_PORTS  per-port error flag (1 = bad frame)
m_tvalid  out  1  output valid
m_tready  in  1  fabric ready
m_tdata  out  DATA_WIDTH  output data
m_tlast  out  1  output end of frame
m_tuser  out  1  output error flag; also set on truncation
m_tid  out  PORT_BITS  source port of the current beat
busy  out  1  a frame is granted and in progress
trunc_pulse  out  1  one-cycle pulse when a frame is truncated
trunc_port  out  PORT_BITS  port index of the last truncation

Behaviour:
- Reset values: all outputs are 0, including s_tready, m_tvalid, busy, trunc_pulse and trunc_port. FSM = IDLE, rr_ptr = 0, beat_cnt = 0.
- FSM states:
  - IDLE: scan s_tvalid starting at rr_ptr and wrapping modulo NUM_PORTS. On the first asserted port g, latch grant = g, go to FWD next cycle. Arbitration latency is 1 cycle, and s_tready stays 0 in IDLE.
  - FWD: s_tready[grant] = !m_tvalid || m_tready; all other s_tready are 0. Each accepted beat loads the output register; m_tid = grant.
  - DISCARD: s_tready[grant] = 1; beats are consumed and not forwarded.
- Output stage: a single registered stage. Holding rule: while m_tvalid && !m_tready, all m_* outputs stay stable. m_tvalid clears when the register drains with no new beat accepted.
- beat_cnt (16 bit):
  - clears on grant;
  - increments on each accepted beat in FWD.
- End of frame in FWD: an accepted beat with s_tlast[grant] = 1 forwards normally (m_tuser = s_tuser[grant]). Then FSM goes to IDLE and rr_ptr = (grant+1) mod NUM_PORTS, wrapping from NUM_PORTS-1 to 0.
- Truncation: an accepted beat with beat_cnt == MAX_BEATS-1 and s_tlast = 0:
  - the beat is forwarded with m_tlast = 1, m_tuser = 1;
  - trunc_pulse = 1 for one cycle, and trunc_port = grant;
  - FSM goes to DISCARD.
- Leaving DISCARD: when the accepted beat has s_tlast = 1, go to IDLE with the rr_ptr update.
- A frame of exactly MAX_BEATS beats with tlast on the last beat is not truncated.
- A new grant may be issued in the same cycle the previous frame's last beat sits in the output register; that beat does not need to drain first.
- busy = 1 in FWD and DISCARD.
- Simultaneous requests: the lowest index at or after rr_ptr wins. Fairness: a port waits at most NUM_PORTS-1 frames.
- A port that drops s_tvalid mid-frame keeps the grant, with no timeout on idle gaps.
- Reset mid-frame: everything returns to reset values immediately and the partial output frame is abandoned. Recovery of downstream framing is the fabric's job.

Decomposition:
- Shared package lc_fabric_pkg holds:
  - typedef port_idx_t (logic[PORT_BITS-1:0]);
  - enum arb_state_t {IDLE, FWD, DISCARD};
  - localparam LC_NUM_PORTS = 24 and the jumbo MAX_BEATS constant.
- One sub-module, rr_priority_picker (combinational: request vector and pointer in, valid and index out), which is reusable by the egress scheduler.

Test Plan:
1. Port 5 only, 4-beat frame (0x11..0x44, tlast on beat 4), m_tready = 1 → out 0x11..0x44 with m_tid = 5, m_tlast on beat 4, first beat appears 2 cycles after s_tvalid; rr_ptr = 6 afterwards.
2. Ports 0, 3 and 23 all valid with 1-beat frames, starting from rr_ptr = 0 → grant order 0, 3, 23, then 0 again if re-requested; no beat interleaving between ports.
3. Port 23 then port 0 → rr_ptr wraps to 0 after port 23's frame; port 0 is granted next.
4. Port 2 streams 2405 beats with no tlast until the end, MAX_BEATS = 2400 → 2400 beats out, beat 2400 has m_tlast = 1 and m_tuser = 1, trunc_pulse is high for one cycle, trunc_port = 2, the 5 remaining beats are dropped, then IDLE.
5. Random m_tready backpressure at 50% → m_* stays stable while stalled, and the output sequence is bit-identical to the no-backpressure run.
6. rst asserted on beat 3 of a 10-beat frame → next edge shows s_tready = 0, m_tvalid = 0, busy = 0; after release a new frame from port 7 is granted from rr_ptr = 0.
